// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the fetch front end.
//   - FSM encodings for pc_sequencer (ST_BOOT/ST_FETCH/ST_EXEC, 2-bit)
//   - exception cause codes
//   - default reset PC and exception vector
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } seq_state_e;

  // Exception cause codes (CP0 Cause.ExcCode encoding)
  localparam logic [4:0] CAUSE_INT  = 5'd0;
  localparam logic [4:0] CAUSE_ADEL = 5'd4;
  localparam logic [4:0] CAUSE_ADES = 5'd5;
  localparam logic [4:0] CAUSE_SYS  = 5'd8;
  localparam logic [4:0] CAUSE_RI   = 5'd10;
  localparam logic [4:0] CAUSE_OV   = 5'd12;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC and sequences instruction fetch
// around the external npc block.
//   clk, rst_n         clock, synchronous active-low reset
//   pc_next            next-PC candidate from npc (fed by pc_cur/ins)
//   imem_req/addr      fetch request (held until ack) and address (= pc_cur)
//   imem_ack/rdata     fetch completion, instruction valid with ack
//   stall              hazard stall, holds pc_cur/ins while executing
//   exc_req/exc_code   execute-stage exception and its cause
//   eret               return to epc
//   pc_cur/ins         current PC and instruction register
//   ins_valid          ins/pc_cur valid for decode/npc
//   epc/cause          saved exception PC (bad address on AdEL) and cause
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter logic [4:0]  ADEL_CODE  = CAUSE_ADEL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic        eret,
  output logic [31:0] pc_cur,
  output logic [31:0] ins,
  output logic        ins_valid,
  output logic [31:0] epc,
  output logic [4:0]  cause
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  cause_q, cause_d;
  logic        req_q, vld_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          ins_d   = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // One event per cycle; exceptions beat eret, both beat stall.
        if (exc_req) begin
          epc_d   = pc_q;
          cause_d = exc_code;
          pc_d    = EXC_VECTOR;
          state_d = ST_FETCH;
        end else if (eret) begin
          pc_d    = epc_q;
          state_d = ST_FETCH;
        end else if (!stall) begin
          if (pc_next[1:0] != 2'b00) begin
            // Misaligned target: record the bad address, not the current PC.
            epc_d   = pc_next;
            cause_d = ADEL_CODE;
            pc_d    = EXC_VECTOR;
          end else begin
            pc_d = pc_next;
          end
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // req/valid are registered copies of the next state so they leave the
  // flops glitch-free alongside pc_cur.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      ins_q   <= '0;
      epc_q   <= '0;
      cause_q <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      req_q   <= (state_d == ST_FETCH);
      vld_q   <= (state_d == ST_EXEC);
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc_cur    = pc_q;
  assign ins       = ins_q;
  assign ins_valid = vld_q;
  assign epc       = epc_q;
  assign cause     = cause_q;

endmodule
